// File: rtl/seq_alu_pkg.sv
// Shared core definitions for the sequential ALU: function codes, FSM states
// and the rule that decides which operations need the iterative datapath.
package seq_alu_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_AND = 3'd2,
    FN_OR  = 3'd3,
    FN_XOR = 3'd4,
    FN_SLT = 3'd5,
    FN_SHL = 3'd6,
    FN_MUL = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A zero-distance shift completes in one cycle, like the plain logic ops.
  function automatic logic needs_iter(input func_e op, input logic shamt_nz);
    return (op == FN_MUL) || ((op == FN_SHL) && shamt_nz);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath shared by MUL (shift-add, DW steps) and SHL (one bit per step).
// res_o/carry_o show the values after the step in progress, so the FSM captures them on the last step.
module alu_iter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          mul_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          last_o,
  output logic [DW-1:0] res_o,
  output logic          carry_o
);

  localparam int LG = $clog2(DW);
  localparam int CW = LG + 1;

  logic          mul_q;
  logic [DW-1:0] mc_q;
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic          c_q;
  logic [CW-1:0] cnt_q;

  logic [DW:0]   sum;
  logic [DW-1:0] hi_d;
  logic [DW-1:0] lo_d;
  logic          c_d;

  // MUL keeps the multiplier in lo_q; product bits shift in from the top as it drains.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    hi_d = hi_q;
    lo_d = lo_q;
    c_d  = c_q;
    if (mul_q) begin
      hi_d = sum[DW:1];
      lo_d = {sum[0], lo_q[DW-1:1]};
    end else begin
      lo_d = {lo_q[DW-2:0], 1'b0};
      c_d  = lo_q[DW-1];
    end
  end

  assign last_o  = (cnt_q == CW'(1));
  assign res_o   = lo_d;
  assign carry_o = mul_q ? (|hi_d) : c_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q <= 1'b0;
      mc_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      mul_q <= mul_i;
      mc_q  <= a_i;
      hi_q  <= '0;
      lo_q  <= mul_i ? b_i : a_i;
      c_q   <= 1'b0;
      cnt_q <= mul_i ? CW'(DW) : CW'(b_i[LG-1:0]);
    end else if (cnt_q != '0) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      c_q   <= c_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: valid/ready handshake, IDLE/BUSY/DONE control, single-cycle ops,
// and the registered result/flags; MUL and non-zero SHL run through alu_iter.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DW = 8,
  parameter int FW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_n
);

  localparam int LG = $clog2(DW);

  state_e        state_q;
  logic [DW-1:0] result_q;
  logic          z_q;
  logic          c_q;
  logic          n_q;

  func_e         op;
  logic          accept;
  logic          shamt_nz;
  logic          start_iter;
  logic [DW:0]   add_d;
  logic [DW:0]   sub_d;
  logic [DW-1:0] res_d;
  logic          c_d;

  logic          iter_last;
  logic [DW-1:0] iter_res;
  logic          iter_carry;

  assign op         = func_e'(func[FUNC_W-1:0]);
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid  = (state_q == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign shamt_nz   = |b[LG-1:0];
  assign start_iter = accept && needs_iter(op, shamt_nz);

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    add_d = {1'b0, a} + {1'b0, b};
    sub_d = {1'b0, a} - {1'b0, b};
    case (op)
      FN_ADD: begin
        res_d = add_d[DW-1:0];
        c_d   = add_d[DW];
      end
      FN_SUB: begin
        res_d = sub_d[DW-1:0];
        c_d   = sub_d[DW];
      end
      FN_AND: res_d = a & b;
      FN_OR:  res_d = a | b;
      FN_XOR: res_d = a ^ b;
      FN_SLT: res_d = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SHL: res_d = a;
      default: ;
    endcase
  end

  alu_iter #(.DW(DW)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_iter),
    .mul_i   (op == FN_MUL),
    .a_i     (a),
    .b_i     (b),
    .last_o  (iter_last),
    .res_o   (iter_res),
    .carry_o (iter_carry)
  );

  // DONE accepts a new op in the same edge it hands off, so IDLE and DONE share one branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (start_iter) begin
              state_q <= ST_BUSY;
            end else begin
              state_q  <= ST_DONE;
              result_q <= res_d;
              c_q      <= c_d;
              z_q      <= (res_d == '0);
              n_q      <= res_d[DW-1];
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (iter_last) begin
            state_q  <= ST_DONE;
            result_q <= iter_res;
            c_q      <= iter_carry;
            z_q      <= (iter_res == '0);
            n_q      <= iter_res[DW-1];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu (DW=8) against an arithmetic reference model.
module tb_seq_alu;

  localparam int DW = 8;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] func = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] result;
  logic          flag_z;
  logic          flag_c;
  logic          flag_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.DW(DW), .FW(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the operation definitions.
  function automatic void model(input int f, input int x, input int y,
                                output int res, output int c, output int lat);
    int full;
    int sx;
    int sy;
    int sh;
    res = 0;
    c   = 0;
    lat = 1;
    case (f)
      0: begin full = x + y; res = full % 256; c = (full > 255) ? 1 : 0; end
      1: begin res = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: begin
        sx  = (x >= 128) ? x - 256 : x;
        sy  = (y >= 128) ? y - 256 : y;
        res = (sx < sy) ? 1 : 0;
      end
      6: begin
        sh  = y % 8;
        res = (x * (1 << sh)) % 256;
        c   = (sh == 0) ? 0 : ((x / (1 << (8 - sh))) % 2);
        lat = sh + 1;
      end
      default: begin
        full = x * y;
        res  = full % 256;
        c    = (full > 255) ? 1 : 0;
        lat  = 9;
      end
    endcase
  endfunction

  task automatic issue(input int f, input int x, input int y);
    func     = f[FW-1:0];
    a        = x[DW-1:0];
    b        = y[DW-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    func     = FW'($urandom);
    a        = DW'($urandom);
    b        = DW'($urandom);
  endtask

  task automatic await_result(input string tag, input int f, input int x, input int y);
    int er;
    int ec;
    int el;
    int lat;
    model(f, x, y, er, ec, el);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, lat, el);
    check({tag, "_result"}, 32'(result), er);
    check({tag, "_flag_c"}, 32'(flag_c), ec);
    check({tag, "_flag_z"}, 32'(flag_z), (er == 0) ? 32'd1 : 32'd0);
    check({tag, "_flag_n"}, 32'(flag_n), er / 128);
    $display("op %s func=%0d a=0x%02h b=0x%02h -> result=0x%02h c=%0d z=%0d n=%0d lat=%0d",
             tag, f, x, y, result, flag_c, flag_z, flag_n, lat);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_after_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input int f, input int x, input int y);
    issue(f, x, y);
    await_result(tag, f, x, y);
    consume(tag);
  endtask

  initial begin
    logic [DW-1:0] held_res;
    logic [2:0]    held_flags;
    int            f;
    int            x;
    int            y;
    int            hold;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    run_op("add_f0_20", 0, 'hF0, 'h20);
    run_op("mul_0d_0b", 7, 'h0D, 'h0B);
    run_op("mul_20_10", 7, 'h20, 'h10);
    run_op("shl_81_01", 6, 'h81, 'h01);
    run_op("shl_81_08", 6, 'h81, 'h08);
    run_op("sub_01_02", 1, 'h01, 'h02);
    run_op("slt_80_01", 5, 'h80, 'h01);
    run_op("slt_01_80", 5, 'h01, 'h80);
    run_op("shl_ff_07", 6, 'hFF, 'h07);

    // Stall in DONE, then hand off and accept in the same edge.
    issue(0, 'h12, 'h34);
    await_result("hold_add", 0, 'h12, 'h34);
    held_res   = result;
    held_flags = {flag_z, flag_c, flag_n};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_result", 32'(result), 32'(held_res));
      check("hold_flags", 32'({flag_z, flag_c, flag_n}), 32'(held_flags));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    func      = 3'd4;
    a         = 8'h5A;
    b         = 8'hC3;
    in_valid  = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    await_result("b2b_xor", 4, 'h5A, 'hC3);
    consume("b2b_xor");

    // Reset during the 4th BUSY cycle of a multiply.
    issue(7, 'h0D, 'h0B);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_busy_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_result", 32'(result), 32'd0);
    check("rst_mid_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
    run_op("after_rst_add", 0, 'h03, 'h04);

    for (int i = 0; i < 60; i++) begin
      f    = int'($urandom_range(0, 7));
      x    = int'($urandom_range(0, 255));
      y    = int'($urandom_range(0, 255));
      hold = int'($urandom_range(0, 2));
      issue(f, x, y);
      await_result("rand", f, x, y);
      held_res = result;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check("rand_hold_result", 32'(result), 32'(held_res));
      end
      consume("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
